// File: rtl/fifo_read_stream.sv
// Read-domain consumer for the async FIFO: pops the FIFO head into a 2-entry skid
// buffer and presents it as a registered valid/ready stream with level and word count.
module fifo_read_stream #(
  parameter int dataWidth  = 8,
  parameter int countWidth = 16
) (
  input  logic                  readClkIn,
  input  logic                  readRstIn,
  input  logic [dataWidth-1:0]  fifoDataIn,
  input  logic                  fifoEmptyIn,
  output logic                  readEnableOut,
  output logic [dataWidth-1:0]  dataOut,
  output logic                  validOut,
  input  logic                  readyIn,
  input  logic                  flushIn,
  output logic [1:0]            levelOut,
  output logic [countWidth-1:0] wordCountOut
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [dataWidth-1:0]  head_reg, head_next;
  logic [dataWidth-1:0]  skid_reg, skid_next;
  logic [countWidth-1:0] count_reg, count_next;
  logic                  valid_reg;
  logic                  pop;
  logic                  accept;

  // Reset is folded into the pop term so the FIFO is never drained while held in reset.
  assign pop    = readRstIn & ~fifoEmptyIn & ~flushIn & (state_reg != TWO);
  assign accept = valid_reg & readyIn;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    count_next = count_reg + {{(countWidth-1){1'b0}}, accept};
    if (flushIn) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (pop) begin
            state_next = ONE;
            head_next  = fifoDataIn;
          end
        end
        ONE: begin
          if (pop && accept) begin
            head_next = fifoDataIn;
          end else if (pop) begin
            state_next = TWO;
            skid_next  = fifoDataIn;
          end else if (accept) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (accept) begin
            state_next = ONE;
            head_next  = skid_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge readClkIn or negedge readRstIn) begin
    if (!readRstIn) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      skid_reg  <= skid_next;
      count_reg <= count_next;
      valid_reg <= (state_next != EMPTY);
    end
  end

  assign readEnableOut = pop;
  assign dataOut       = head_reg;
  assign validOut      = valid_reg;
  assign levelOut      = state_reg;
  assign wordCountOut  = count_reg;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Scoreboard bench for fifo_read_stream: a queue models the FIFO, expected stream
// words are queued at load time and a negedge monitor checks every accepted word.
module tb_fifo_read_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        read_enable;
  logic [7:0]  data;
  logic        valid;
  logic        ready = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  level;
  logic [15:0] count;

  logic        d4_read_enable;
  logic [7:0]  d4_data;
  logic        d4_valid;
  logic [1:0]  d4_level;
  logic [3:0]  d4_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;
  bit p;

  always #5 clk = ~clk;

  fifo_read_stream #(.dataWidth(8), .countWidth(16)) dut (
    .readClkIn(clk), .readRstIn(rst_n), .fifoDataIn(fifo_data), .fifoEmptyIn(fifo_empty),
    .readEnableOut(read_enable), .dataOut(data), .validOut(valid), .readyIn(ready),
    .flushIn(flush), .levelOut(level), .wordCountOut(count)
  );

  fifo_read_stream #(.dataWidth(8), .countWidth(4)) dut4 (
    .readClkIn(clk), .readRstIn(rst_n), .fifoDataIn(fifo_data), .fifoEmptyIn(fifo_empty),
    .readEnableOut(d4_read_enable), .dataOut(d4_data), .validOut(d4_valid), .readyIn(ready),
    .flushIn(flush), .levelOut(d4_level), .wordCountOut(d4_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic load(input logic [7:0] d, input bit expect_out);
    fifo_q.push_back(d);
    if (expect_out) exp_q.push_back(d);
    refresh();
  endtask

  // One clock: sample the pop strobe at negedge, retire the popped word after the edge.
  task automatic tick(output bit popped);
    @(negedge clk);
    popped = read_enable;
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic ticks(input int n);
    bit dummy;
    for (int i = 0; i < n; i++) tick(dummy);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("pop_in_reset", 32'(read_enable), 32'd0);
    end else begin
      if (read_enable) check("pop_guard", 32'(fifo_empty || level == 2'd2), 32'd0);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(data), 32'h100);
        end else begin
          exp_word = exp_q.pop_front();
          check("stream_data", 32'(data), 32'(exp_word));
          $display("accept data=%02h count=%0d", data, count);
        end
      end
    end
  end

  initial begin
    // Basic: 3 words back-to-back; FIFO already non-empty during reset
    load(8'h11, 1); load(8'h22, 1); load(8'h33, 1);
    ticks(2);
    check("rst_valid", 32'(valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_data", 32'(data), 0);
    check("rst_count", 32'(count), 0);
    check("rst_pop", 32'(read_enable), 0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick(p); check("t1_pop1", 32'(p), 1);
    check("t1_valid", 32'(valid), 1); check("t1_data1", 32'(data), 32'h11);
    tick(p); check("t1_pop2", 32'(p), 1); check("t1_data2", 32'(data), 32'h22);
    tick(p); check("t1_pop3", 32'(p), 1); check("t1_data3", 32'(data), 32'h33);
    tick(p); check("t1_pop4", 32'(p), 0);
    check("t1_level", 32'(level), 0); check("t1_count", 32'(count), 3);

    // Stall with both entries full
    for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i), 1);
    tick(p);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(p);
      if (i > 0) check("t2_no_pop_full", 32'(p), 0);
      check("t2_level", 32'(level), 2);
      check("t2_hold_data", 32'(data), 32'hA0);
      check("t2_hold_valid", 32'(valid), 1);
    end
    ready = 1'b1;
    ticks(8);
    check("t2_level_end", 32'(level), 0);
    check("t2_count", 32'(count), 8);
    check("t2_drained", 32'(exp_q.size()), 0);

    // Empty FIFO, ready toggling
    for (int i = 0; i < 6; i++) begin
      ready = i[0];
      tick(p);
      check("t3_no_pop", 32'(p), 0);
      check("t3_valid", 32'(valid), 0);
    end
    check("t3_count", 32'(count), 8);

    // Flush at level 2: 0x55 accepted in the flush cycle, 0x66 discarded
    ready = 1'b0;
    load(8'h55, 1); load(8'h66, 0); load(8'h77, 1);
    ticks(2);
    check("t4_level2", 32'(level), 2);
    check("t4_head", 32'(data), 32'h55);
    flush = 1'b1; ready = 1'b1;
    tick(p); check("t4_flush_no_pop", 32'(p), 0);
    flush = 1'b0;
    check("t4_level0", 32'(level), 0);
    check("t4_valid0", 32'(valid), 0);
    check("t4_count", 32'(count), 9);
    tick(p); check("t4_pop_after", 32'(p), 1);
    tick(p);
    check("t4_count2", 32'(count), 10);

    // Flush at level 1 with a non-empty FIFO: the flush alone must block the pop
    ready = 1'b0;
    load(8'h88, 0); load(8'h99, 1);
    tick(p); check("t4b_pop", 32'(p), 1);
    flush = 1'b1;
    tick(p); check("t4b_flush_no_pop", 32'(p), 0);
    flush = 1'b0; ready = 1'b1;
    check("t4b_level0", 32'(level), 0);
    check("t4b_count", 32'(count), 10);
    ticks(2);
    check("t4b_count2", 32'(count), 11);
    check("t4b_drained", 32'(exp_q.size()), 0);

    // Counter wrap on the 4-bit instance
    rst_n = 1'b0; ticks(2); rst_n = 1'b1;
    check("t5_count_rst", 32'(d4_count), 0);
    for (int i = 0; i < 17; i++) load(8'(i), 1);
    for (int i = 1; i <= 20; i++) begin
      tick(p);
      if (i == 17) begin
        check("t5_wrap4", 32'(d4_count), 0);
        check("t5_count16", 32'(count), 16);
      end
    end
    check("t5_count17", 32'(count), 17);
    check("t5_count4", 32'(d4_count), 1);
    check("t5_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset with two words buffered
    load(8'hB0, 0); load(8'hB1, 0); load(8'hB2, 1); load(8'hB3, 1);
    tick(p);
    ready = 1'b0;
    tick(p);
    check("t6_level2", 32'(level), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(valid), 0);
    check("t6_level", 32'(level), 0);
    check("t6_count", 32'(count), 0);
    check("t6_count4", 32'(d4_count), 0);
    check("t6_data", 32'(data), 0);
    check("t6_pop", 32'(read_enable), 0);
    tick(p); check("t6_no_pop_rst", 32'(p), 0);
    rst_n = 1'b1; ready = 1'b1;
    tick(p); check("t6_first_pop", 32'(p), 1);
    check("t6_data_b2", 32'(data), 32'hB2);
    ticks(3);
    check("t6_count_end", 32'(count), 2);
    check("t6_level_end", 32'(level), 0);
    check("t6_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
